// File: rtl/mips_mdu.sv
// mips_mdu: iterative multiply/divide unit with HI/LO registers.
// Handles MULT, MULTU, DIV, DIVU (multi-cycle) and MTHI, MTLO (immediate
// register writes); rdata returns HI/LO for MFHI/MFLO.
// Multiply is shift-add on a 2*WIDTH product register; divide is restoring,
// one quotient bit per cycle, sharing the same register as {rem, quo}.
// Handshake: busy is high while state != IDLE; done (and div_by_zero) pulse
// for one cycle as HI/LO are written. start is only honoured in IDLE.
// Optional build macro: MIPS_MDU_EARLY_OUT_EN -- multiply leaves CALC as soon
// as the remaining multiplier bits are zero; the product is realigned in FIX.
module mips_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;       // product, or {remainder, quotient}
    logic [WIDTH-1:0]   opnd_q, opnd_d;     // |multiplicand| or |divisor|
    logic               div_q, div_d;       // 1 = divide in flight
    logic               neg_q, neg_d;       // result (product/quotient) negated
    logic               rem_neg_q, rem_neg_d;
    logic               dbz_q, dbz_d;       // divisor was zero
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_out_q, dbz_out_d;

    // Decode of the incoming request
    logic             req_mul, req_div, req_signed, sign_a, sign_b;
    logic [WIDTH-1:0] a_mag, b_mag;

    // One datapath iteration of each kind
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_step;

    // Result correction in FIX
    logic [2*WIDTH-1:0] mul_prod, mul_res;
    logic [WIDTH-1:0]   div_quo, div_rem;

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_out_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign state_dbg   = state_q;

    // MFHI/MFLO read port, purely a function of funct
    always_comb begin
        rdata = '0;
        if (funct == F_MFHI)      rdata = hi_q;
        else if (funct == F_MFLO) rdata = lo_q;
    end

    // Request decode and operand magnitudes
    always_comb begin
        req_mul    = (funct == F_MULT) || (funct == F_MULTU);
        req_div    = (funct == F_DIV)  || (funct == F_DIVU);
        req_signed = (funct == F_MULT) || (funct == F_DIV);
        sign_a     = req_signed & a[WIDTH-1];
        sign_b     = req_signed & b[WIDTH-1];
        a_mag      = sign_a ? -a : a;
        b_mag      = sign_b ? -b : b;
    end

    // Shift-add and restoring-divide iteration steps
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift - {1'b0, opnd_q};
        div_step  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
    end

`ifdef MIPS_MDU_EARLY_OUT_EN
    // cnt_q shifts were skipped by the early exit; finish them here
    assign mul_prod = acc_q >> cnt_q;
`else
    assign mul_prod = acc_q;
`endif

    // Sign correction of the finished results
    always_comb begin
        mul_res = neg_q ? -mul_prod : mul_prod;
        div_quo = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        div_rem = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

`ifdef MIPS_MDU_EARLY_OUT_EN
    logic [WIDTH-1:0] rem_mask;
    // Positions still holding unconsumed multiplier bits after this step
    assign rem_mask = (WIDTH'(1) << cnt_q) - WIDTH'(1);
`endif

    // FSM next-state and register updates
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        div_d     = div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (funct == F_MTHI) begin
                        hi_d = a;
                    end else if (funct == F_MTLO) begin
                        lo_d = a;
                    end else if (req_mul || req_div) begin
                        state_d   = CALC;
                        cnt_d     = CNT_W'(WIDTH - 1);
                        div_d     = req_div;
                        neg_d     = sign_a ^ sign_b;
                        rem_neg_d = sign_a;
                        dbz_d     = req_div && (b == '0);
                        // multiply: multiplicand |a|, multiplier |b| in the low half
                        // divide:   divisor |b|, dividend |a| in the low half
                        opnd_d    = req_div ? b_mag : a_mag;
                        acc_d     = {{WIDTH{1'b0}}, (req_div ? a_mag : b_mag)};
                    end
                end
            end
            CALC: begin
                acc_d = div_q ? div_step : mul_step;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
`ifdef MIPS_MDU_EARLY_OUT_EN
                    if (!div_q && ((mul_step[WIDTH-1:0] & rem_mask) == '0)) begin
                        state_d = FIX;
                        cnt_d   = cnt_q;
                    end
`endif
                end
            end
            FIX: begin
                state_d   = IDLE;
                cnt_d     = '0;
                done_d    = 1'b1;
                dbz_out_d = div_q & dbz_q;
                if (div_q) begin
                    hi_d = div_rem;
                    lo_d = dbz_q ? '1 : div_quo;
                end else begin
                    hi_d = mul_res[2*WIDTH-1:WIDTH];
                    lo_d = mul_res[WIDTH-1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation without a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
        end
    end

endmodule

// File: tb/tb_mips_mdu.sv
// tb_mips_mdu: directed test of mips_mdu (WIDTH=32, default build).
// Expected values are hand-computed constants; inputs change #1 after the
// rising edge, outputs are sampled at the same point.
module tb_mips_mdu;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'd0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo, rdata;
    logic [1:0]  state_dbg;

    int total_cnt  = 0;
    int passed_cnt = 0;
    int failed_cnt = 0;

    mips_mdu #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .funct       (funct),
        .a           (a_i),
        .b           (b_i),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .rdata       (rdata),
        .state_dbg   (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) passed_cnt++;
        else begin
            failed_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Present a request for exactly one rising edge
    task automatic pulse_start(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        funct = f;
        a_i   = x;
        b_i   = y;
        @(posedge clk); #1;
        start = 1'b0;
        funct = 6'd0;
    endtask

    // Count edges until done, bounded; also count cycles with busy high
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dbz);
        int lat, bcnt;
        pulse_start(f, x, y);
        wait_done(lat, bcnt);
        check({tag, ".latency"}, 64'(lat), 64'd33);
        check({tag, ".busy_cycles"}, 64'(bcnt), 64'd33);
        check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
        check({tag, ".lo"}, 64'(lo), 64'(exp_lo));
        check({tag, ".dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, 64'(done), 64'd0);
        check({tag, ".dbz_pulse"}, 64'(div_by_zero), 64'd0);
    endtask

    initial begin
        int lat, bcnt, done_seen;

        // Reset with a MULT request pending: reset must win
        reset = 1'b1;
        start = 1'b1;
        funct = F_MULT;
        a_i   = 32'h0000_0005;
        b_i   = 32'h0000_0003;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.hi", 64'(hi), 64'd0);
        check("reset.lo", 64'(lo), 64'd0);
        check("reset.dbz", 64'(div_by_zero), 64'd0);
        start = 1'b0;
        funct = 6'd0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("reset.idle_busy", 64'(busy), 64'd0);

        // MTHI / MTLO while idle, and the MFHI/MFLO read port
        pulse_start(F_MTHI, 32'h1234_5678, 32'h0);
        check("mthi.hi", 64'(hi), 64'h1234_5678);
        check("mthi.busy", 64'(busy), 64'd0);
        check("mthi.done", 64'(done), 64'd0);
        funct = F_MFHI; #1;
        check("mfhi.rdata", 64'(rdata), 64'h1234_5678);
        funct = 6'd0;
        pulse_start(F_MTLO, 32'hCAFE_F00D, 32'h0);
        check("mtlo.lo", 64'(lo), 64'hCAFE_F00D);
        check("mtlo.hi_kept", 64'(hi), 64'h1234_5678);
        funct = F_MFLO; #1;
        check("mflo.rdata", 64'(rdata), 64'hCAFE_F00D);
        funct = F_MULT; #1;
        check("other.rdata", 64'(rdata), 64'd0);
        funct = 6'd0;

        // Multiply
        run_op("mult_m1x2", F_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("multu_m1x2", F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        run_op("mult_max", F_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("mult_m3x5", F_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);

        // Divide, including divide by zero and signed overflow
        run_op("div_m7d2", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_7d0", F_DIVU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("div_m5d0", F_DIV, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

        // MTLO while busy is ignored; the running MULTU is not disturbed
        pulse_start(F_MULTU, 32'h0000_0003, 32'h0000_0004);
        pulse_start(F_MTLO, 32'hDEAD_BEEF, 32'h0);
        check("mtlo_busy.lo_kept", 64'(lo), 64'hFFFF_FFFF);
        check("mtlo_busy.busy", 64'(busy), 64'd1);
        wait_done(lat, bcnt);
        check("mtlo_busy.latency", 64'(lat + 1), 64'd33);
        check("mtlo_busy.hi", 64'(hi), 64'h0000_0000);
        check("mtlo_busy.lo", 64'(lo), 64'h0000_000C);

        // Start in the done cycle is accepted
        check("back2back.done_now", 64'(done), 64'd1);
        pulse_start(F_DIVU, 32'd100, 32'd7);
        check("back2back.busy", 64'(busy), 64'd1);
        wait_done(lat, bcnt);
        check("back2back.latency", 64'(lat), 64'd33);
        check("back2back.lo", 64'(lo), 64'd14);
        check("back2back.hi", 64'(hi), 64'd2);

        // Reset 10 cycles into a MULT: aborts with no done pulse
        pulse_start(F_MULT, 32'h0000_1234, 32'h0000_5678);
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("abort.busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.hi", 64'(hi), 64'd0);
        check("abort.lo", 64'(lo), 64'd0);
        done_seen = 0;
        repeat (40) begin
            if (done === 1'b1) done_seen++;
            @(posedge clk); #1;
        end
        check("abort.no_done", 64'(done_seen), 64'd0);
        check("abort.lo_after", 64'(lo), 64'd0);

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
